// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier arbiter FSM states and multiplier constants.
package alu_pkg;

  // Multiplier core latency (cycles mul_active stays high) and operand width.
  localparam int MULT_LAT = 32;
  localparam int MULT_W   = 32;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mult_arb_state_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-side bus of the shared multiplier arbiter.
// Handshake: a requester holds req[i] and its operand slices stable until it
// sees gnt[i] (one-cycle pulse); the result returns later as a one-cycle
// rsp_valid[i] pulse with rsp_id and rsp_product valid in that same cycle.
interface mult_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 32
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [2*W-1:0]     rsp_product;

  // Arbiter side.
  modport slave (
    input  req, req_a, req_b,
    output gnt, rsp_valid, rsp_id, rsp_product
  );

  // Requester side.
  modport master (
    output req, req_a, req_b,
    input  gnt, rsp_valid, rsp_id, rsp_product
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after 'last'
// (wrapping modulo N_REQ) wins.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDW-1:0]   win_idx,
  output logic             any
);

  logic [IDW-1:0] cand;

  // Scan from the lowest priority candidate (last) up to the highest (last+1)
  // so the highest-priority requesting candidate is written last and wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    cand    = '0;
    any     = |req;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDW'((int'(last) + k) % N_REQ);
      if (req[cand]) begin
        win_oh       = '0;
        win_oh[cand] = 1'b1;
        win_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin front end sharing one sequential multiplier between N_REQ
// requesters. Latches the winner's operands, runs the start/active/done
// handshake and returns the signed 2*W product tagged with the winner index.
// Optional feature: define MULT_SHARE_ZERO_BYPASS_EN to answer grants with a
// zero operand directly (IDLE -> RESP, product 0) without using the multiplier.
module mult_share_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = MULT_W,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_share_arbiter_if.slave  bus,
  output logic                 busy,
  output logic                 mul_start,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  input  logic [2*W-1:0]       mul_product,
  input  logic                 mul_done,
  input  logic                 mul_active,
  output mult_arb_state_t      dbg_state
);

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  mult_arb_state_t  state;
  logic [IDW-1:0]   last;
  logic             seen_active;

  logic [N_REQ-1:0] pick_oh;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;
  logic             zero_op;
  logic             do_grant;
  int               sel_base;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
    .req     (bus.req),
    .last    (last),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // Winner operand selection and grant decision. A grant may be issued from
  // IDLE or in the cycle after the result pulse (RESP), so back-to-back
  // operations are spaced exactly one product period apart. No grant while a
  // multiplier operation (possibly left over from before reset) is active.
  always_comb begin
    sel_base = int'(pick_idx) * W;
    a_sel    = bus.req_a[sel_base +: W];
    b_sel    = bus.req_b[sel_base +: W];
`ifdef MULT_SHARE_ZERO_BYPASS_EN
    zero_op  = (a_sel == '0) || (b_sel == '0);
`else
    zero_op  = 1'b0;
`endif
    do_grant = pick_any && !mul_active &&
               ((state == ST_IDLE) ||
                ((state == ST_RESP) && (bus.rsp_valid != '0)));
  end

  // Arbiter FSM with registered outputs; gnt, mul_start and rsp_valid are
  // single-cycle pulses cleared by default every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      last            <= IDW'(N_REQ - 1);
      seen_active     <= 1'b0;
      mul_start       <= 1'b0;
      mul_a           <= '0;
      mul_b           <= '0;
      bus.gnt         <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_id      <= '0;
      bus.rsp_product <= '0;
    end else begin
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      mul_start     <= 1'b0;
      if (do_grant) begin
        bus.gnt     <= pick_oh;
        mul_a       <= a_sel;
        mul_b       <= b_sel;
        bus.rsp_id  <= pick_idx;
        last        <= pick_idx;
        seen_active <= 1'b0;
        if (zero_op) begin
          bus.rsp_product <= '0;
          state           <= ST_RESP;
        end else begin
          state <= ST_ISSUE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            seen_active <= 1'b0;
          end
          ST_ISSUE: begin
            mul_start <= 1'b1;
            state     <= ST_WAIT;
          end
          ST_WAIT: begin
            if (mul_active) begin
              seen_active <= 1'b1;
            end
            // done only counts once this operation has been seen active,
            // which filters out a stale done from an earlier operation.
            if (mul_done && !mul_active && seen_active) begin
              bus.rsp_product <= mul_product;
              bus.rsp_valid   <= ONE_HOT0 << bus.rsp_id;
              state           <= ST_RESP;
            end
          end
          ST_RESP: begin
            // Entered from WAIT the pulse is already out; entered from a
            // bypassed grant it is emitted here, one cycle after the grant.
            if (bus.rsp_valid != '0) begin
              state <= ST_IDLE;
            end else begin
              bus.rsp_valid <= ONE_HOT0 << bus.rsp_id;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier model.
module tb_mult_share_arbiter;
  import alu_pkg::*;

  localparam int N_REQ = 4;
  localparam int W     = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  mult_share_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

  logic            busy;
  logic            mul_start;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic [2*W-1:0]  mul_product;
  logic            mul_done;
  logic            mul_active;
  mult_arb_state_t dbg_state;

  mult_share_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .busy        (busy),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .mul_done    (mul_done),
    .mul_active  (mul_active),
    .dbg_state   (dbg_state)
  );

  // ---------------- multiplier model (not reset with the arbiter) ----------------
  logic           m_active = 1'b0;
  logic           m_done   = 1'b0;
  int             m_cnt    = 0;
  logic [2*W-1:0] m_prod   = '0;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (m_active) begin
      if (m_cnt == 31) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (mul_start) begin
      m_active <= 1'b1;
      m_cnt    <= 0;
      m_prod   <= $signed(mul_a) * $signed(mul_b);
    end
  end

  assign mul_active  = m_active;
  assign mul_done    = m_done;
  assign mul_product = m_prod;

  // ---------------- monitors ----------------
  int n_start   = 0;
  int n_rsp     = 0;
  int n_overlap = 0;
  int n_act_gnt = 0;

  always @(negedge clk) begin
    if (mul_start === 1'b1) n_start++;
    if (|bus.rsp_valid === 1'b1) n_rsp++;
    if ((|bus.gnt === 1'b1) && (|bus.rsp_valid === 1'b1)) n_overlap++;
    if ((|bus.gnt === 1'b1) && (mul_active === 1'b1)) n_act_gnt++;
  end

  // ---------------- scoreboard / checks ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[idx*W +: W] = a;
    bus.req_b[idx*W +: W] = b;
    bus.req[idx]          = 1'b1;
  endtask

  task automatic drop_req(input int idx);
    bus.req[idx] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_gnt(input int budget, output int t, output logic ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (|bus.gnt === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
  endtask

  task automatic wait_rsp(input int budget, output int t, output logic ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (|bus.rsp_valid === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int             tg;
  int             tg_prev;
  int             tr;
  int             s0;
  int             r0;
  logic           ok;
  int             order [5];
  logic [63:0]    prod4 [4];

  initial begin
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gnt",       64'(bus.gnt), 64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_busy",      64'(busy), 64'h0);
    check("rst_mul_start", 64'(mul_start), 64'h0);
    check("rst_mul_a",     64'(mul_a), 64'h0);
    check("rst_product",   bus.rsp_product, 64'h0);
    check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b1;

    // Single request: 7 * -3 = -21
    set_req(0, 32'd7, 32'hFFFF_FFFD);
    wait_gnt(10, tg, ok);
    check("s1_gnt_seen", 64'(ok), 64'h1);
    check("s1_gnt", 64'(bus.gnt), 64'h1);
    check("s1_mul_a", 64'(mul_a), 64'h7);
    check("s1_mul_b", 64'(mul_b), 64'hFFFF_FFFD);
    check("s1_busy", 64'(busy), 64'h1);
    drop_req(0);
    @(negedge clk);
    check("s1_mul_start", 64'(mul_start), 64'h1);
    wait_rsp(60, tr, ok);
    check("s1_rsp_seen", 64'(ok), 64'h1);
    check("s1_latency", 64'(tr - tg), 64'd35);
    check("s1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("s1_rsp_id", 64'(bus.rsp_id), 64'h0);
    check("s1_product", bus.rsp_product, 64'hFFFF_FFFF_FFFF_FFEB);

    // Extreme operands
    set_req(1, 32'h8000_0000, 32'h8000_0000);
    wait_gnt(10, tg, ok);
    check("ext1_gnt", 64'(bus.gnt), 64'h2);
    drop_req(1);
    wait_rsp(60, tr, ok);
    check("ext1_latency", 64'(tr - tg), 64'd35);
    check("ext1_rsp_id", 64'(bus.rsp_id), 64'h1);
    check("ext1_product", bus.rsp_product, 64'h4000_0000_0000_0000);

    set_req(2, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    wait_gnt(10, tg, ok);
    check("ext2_gnt", 64'(bus.gnt), 64'h4);
    drop_req(2);
    wait_rsp(60, tr, ok);
    check("ext2_rsp_valid", 64'(bus.rsp_valid), 64'h4);
    check("ext2_rsp_id", 64'(bus.rsp_id), 64'h2);
    check("ext2_product", bus.rsp_product, 64'hFFFF_FFFF_8000_0001);

    // All four requesting continuously after a fresh reset
    @(negedge clk);
    do_reset(3);
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    prod4[0] = 64'd15;
    prod4[1] = 64'hFFFF_FFFF_FFFF_FFEE;
    prod4[2] = 64'h0000_0002_540B_E400;
    prod4[3] = 64'd56;
    set_req(0, 32'd3, 32'd5);
    set_req(1, 32'hFFFF_FFFE, 32'd9);
    set_req(2, 32'd100000, 32'd100000);
    set_req(3, 32'hFFFF_FFF9, 32'hFFFF_FFF8);
    tg_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(80, tg, ok);
      check($sformatf("rr%0d_gnt_seen", i), 64'(ok), 64'h1);
      check($sformatf("rr%0d_gnt", i), 64'(bus.gnt), 64'h1 << order[i]);
      if (i > 0) check($sformatf("rr%0d_spacing", i), 64'(tg - tg_prev), 64'd36);
      tg_prev = tg;
      if (i == 4) bus.req = '0;
      wait_rsp(80, tr, ok);
      check($sformatf("rr%0d_latency", i), 64'(tr - tg), 64'd35);
      check($sformatf("rr%0d_rsp_valid", i), 64'(bus.rsp_valid), 64'h1 << order[i]);
      check($sformatf("rr%0d_rsp_id", i), 64'(bus.rsp_id), 64'(order[i]));
      check($sformatf("rr%0d_product", i), bus.rsp_product, prod4[order[i]]);
    end

    // Requester 1 drops before being granted; requester 3 held
    set_req(0, 32'd1, 32'd1);
    wait_gnt(10, tg, ok);
    check("drop_gnt0", 64'(bus.gnt), 64'h1);
    drop_req(0);
    repeat (5) @(negedge clk);
    set_req(1, 32'd11, 32'd13);
    set_req(3, 32'd6, 32'd7);
    repeat (10) @(negedge clk);
    drop_req(1);
    wait_rsp(60, tr, ok);
    check("drop_prod0", bus.rsp_product, 64'd1);
    wait_gnt(10, tg, ok);
    check("drop_gnt3", 64'(bus.gnt), 64'h8);
    drop_req(3);
    set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp(60, tr, ok);
    check("drop_rsp3_id", 64'(bus.rsp_id), 64'h3);
    check("drop_prod3", bus.rsp_product, 64'd42);
    wait_gnt(10, tg, ok);
    check("readd_gnt1", 64'(bus.gnt), 64'h2);
    drop_req(1);
    wait_rsp(60, tr, ok);
    check("readd_rsp_id", 64'(bus.rsp_id), 64'h1);
    check("readd_prod", bus.rsp_product, 64'd1);

    // Reset during WAIT while the multiplier keeps running
    set_req(0, 32'd2, 32'd3);
    wait_gnt(10, tg, ok);
    check("mid_gnt", 64'(bus.gnt), 64'h1);
    drop_req(0);
    while (cyc < tg + 19) @(negedge clk);
    r0  = n_rsp;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_active_left", 64'(mul_active), 64'h1);
    check("mid_busy", 64'(busy), 64'h0);
    check("mid_product_clr", bus.rsp_product, 64'h0);
    check("mid_mul_a_clr", 64'(mul_a), 64'h0);
    rst = 1'b1;
    set_req(0, 32'd4, 32'd5);
    wait_gnt(60, tg_prev, ok);
    check("mid_regnt_seen", 64'(ok), 64'h1);
    check("mid_regnt_time", 64'(tg_prev - tg), 64'd35);
    check("mid_no_rsp", 64'(n_rsp - r0), 64'h0);
    drop_req(0);
    wait_rsp(60, tr, ok);
    check("mid_latency", 64'(tr - tg_prev), 64'd35);
    check("mid_product", bus.rsp_product, 64'd20);

    // Zero operand
    s0 = n_start;
    set_req(2, 32'd0, 32'd5);
    wait_gnt(10, tg, ok);
    check("zero_gnt", 64'(bus.gnt), 64'h4);
    drop_req(2);
    wait_rsp(60, tr, ok);
    check("zero_rsp_valid", 64'(bus.rsp_valid), 64'h4);
    check("zero_product", bus.rsp_product, 64'h0);
`ifdef MULT_SHARE_ZERO_BYPASS_EN
    check("zero_latency", 64'(tr - tg), 64'd1);
    check("zero_starts", 64'(n_start - s0), 64'd0);
`else
    check("zero_latency", 64'(tr - tg), 64'd35);
    check("zero_starts", 64'(n_start - s0), 64'd1);
`endif

    repeat (3) @(negedge clk);
    check("end_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("gnt_rsp_overlap", 64'(n_overlap), 64'h0);
    check("gnt_while_active", 64'(n_act_gnt), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
